// File: rtl/ddr_types_pkg.sv
// Shared command types and default DDR timing constants for the command timing gate.
// Timing values are in controller clock cycles.
package ddr_types_pkg;

    localparam int DDR_NUM_RANKS = 2;
    localparam int DDR_NUM_BANKS = 32;
    localparam int DDR_CW        = 10;
    localparam int DDR_TRCD      = 26;
    localparam int DDR_TRAS      = 52;
    localparam int DDR_TRP       = 26;
    localparam int DDR_TRRD      = 8;
    localparam int DDR_TRFC      = 472;
    localparam int DDR_TCCD      = 8;

    // Rank field carries a spare bit so an out-of-range rank can reach the gate.
    localparam int DDR_RANK_W    = 2;
    localparam int DDR_BANK_W    = 5;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } ddr_op_e;

    typedef struct packed {
        ddr_op_e                op;
        logic [DDR_RANK_W-1:0]  rank;
        logic [DDR_BANK_W-1:0]  bank;
    } ddr_cmd_t;

endpackage

// File: rtl/ddr_bank_timer.sv
// Per-bank open flag plus tRCD/tRAS/tRP countdowns.
// ACT opens the bank and loads tRCD/tRAS; PRE closes it and loads tRP.
module ddr_bank_timer
    import ddr_types_pkg::*;
#(
    parameter int CW   = DDR_CW,
    parameter int TRCD = DDR_TRCD,
    parameter int TRAS = DDR_TRAS,
    parameter int TRP  = DDR_TRP
) (
    input  logic clk,
    input  logic rst,
    input  logic act_ld,
    input  logic pre_ld,
    output logic is_open,
    output logic rcd_ok,
    output logic ras_ok,
    output logic rp_ok
);

    logic [CW-1:0] rcd_q;
    logic [CW-1:0] ras_q;
    logic [CW-1:0] rp_q;

    // Loading T-1 spaces the issuing clock edges by at least T cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_open <= 1'b0;
            rcd_q   <= '0;
            ras_q   <= '0;
            rp_q    <= '0;
        end else begin
            if (act_ld) begin
                is_open <= 1'b1;
                rcd_q   <= CW'(TRCD - 1);
                ras_q   <= CW'(TRAS - 1);
            end else begin
                if (rcd_q != '0) rcd_q <= rcd_q - CW'(1);
                if (ras_q != '0) ras_q <= ras_q - CW'(1);
            end
            if (pre_ld) begin
                is_open <= 1'b0;
                rp_q    <= CW'(TRP - 1);
            end else if (rp_q != '0) begin
                rp_q <= rp_q - CW'(1);
            end
        end
    end

    assign rcd_ok = (rcd_q == '0);
    assign ras_ok = (ras_q == '0);
    assign rp_ok  = (rp_q == '0);

endmodule

// File: rtl/ddr_cmd_timing_gate.sv
// Holds scheduler commands until DDR timing-legal, issuing through a one-entry output register.
// Optional `DDR_CMD_GATE_STATS_EN enables the saturating stall_cycles counter.
module ddr_cmd_timing_gate
    import ddr_types_pkg::*;
#(
    parameter int NUM_RANKS = DDR_NUM_RANKS,
    parameter int NUM_BANKS = DDR_NUM_BANKS,
    parameter int CW        = DDR_CW,
    parameter int TRCD      = DDR_TRCD,
    parameter int TRAS      = DDR_TRAS,
    parameter int TRP       = DDR_TRP,
    parameter int TRRD      = DDR_TRRD,
    parameter int TRFC      = DDR_TRFC,
    parameter int TCCD      = DDR_TCCD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  ddr_cmd_t    cmd,
    output logic        phy_valid,
    input  logic        phy_ready,
    output ddr_cmd_t    phy_cmd,
    output logic        bank_busy,
    output logic        rank_busy,
    output logic        proto_err,
    output logic [15:0] stall_cycles
);

    localparam int RK_W = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1;
    localparam int BK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic [NUM_BANKS-1:0] bank_open [NUM_RANKS];
    logic [NUM_BANKS-1:0] rcd_ok    [NUM_RANKS];
    logic [NUM_BANKS-1:0] ras_ok    [NUM_RANKS];
    logic [NUM_BANKS-1:0] rp_ok     [NUM_RANKS];
    logic [CW-1:0]        trrd_q    [NUM_RANKS];
    logic [CW-1:0]        trfc_q    [NUM_RANKS];
    logic [CW-1:0]        tccd_q;

    logic [RK_W-1:0]      rk;
    logic [BK_W-1:0]      bk;
    logic                 in_range;
    logic [NUM_RANKS-1:0] rank_sel;
    logic [NUM_BANKS-1:0] bank_sel;
    logic                 trfc_busy;
    logic                 state_err;
    logic                 bank_blk;
    logic                 rank_blk;
    logic                 legal;
    logic                 slot_free;
    logic                 issue;
    logic                 drop;

    assign rk       = cmd.rank[RK_W-1:0];
    assign bk       = cmd.bank[BK_W-1:0];
    assign in_range = (int'(cmd.rank) < NUM_RANKS) && (int'(cmd.bank) < NUM_BANKS);

    always_comb begin
        rank_sel     = '0;
        bank_sel     = '0;
        rank_sel[rk] = 1'b1;
        bank_sel[bk] = 1'b1;
    end

    // tCCD is column-command spacing, so it is reported through bank_busy.
    always_comb begin
        state_err = 1'b0;
        bank_blk  = 1'b0;
        rank_blk  = 1'b0;
        trfc_busy = (trfc_q[rk] != '0);
        if (cmd.op != CMD_NOP && !in_range) begin
            state_err = 1'b1;
        end else begin
            case (cmd.op)
                CMD_NOP: ;
                CMD_ACT: begin
                    state_err = bank_open[rk][bk];
                    bank_blk  = !rp_ok[rk][bk];
                    rank_blk  = (trrd_q[rk] != '0) || trfc_busy;
                end
                CMD_RD, CMD_WR: begin
                    state_err = !bank_open[rk][bk];
                    bank_blk  = !rcd_ok[rk][bk] || (tccd_q != '0);
                    rank_blk  = trfc_busy;
                end
                CMD_PRE: begin
                    state_err = !bank_open[rk][bk];
                    bank_blk  = !ras_ok[rk][bk];
                    rank_blk  = trfc_busy;
                end
                CMD_REF: begin
                    state_err = |bank_open[rk];
                    bank_blk  = !(&rp_ok[rk]);
                    rank_blk  = trfc_busy;
                end
                default: state_err = 1'b1;
            endcase
        end
    end

    // Handshake: a transfer happens on an edge where valid && ready. cmd_ready is also raised for
    // protocol-illegal commands, which are consumed and dropped. phy_cmd is held while phy_valid && !phy_ready.
    assign legal     = !state_err && !bank_blk && !rank_blk;
    assign slot_free = !phy_valid || phy_ready;
    assign cmd_ready = cmd_valid && slot_free && (legal || state_err);
    assign issue     = cmd_ready && legal && (cmd.op != CMD_NOP);
    assign drop      = cmd_ready && state_err;
    assign bank_busy = cmd_valid && !state_err && bank_blk;
    assign rank_busy = cmd_valid && !state_err && rank_blk;

    for (genvar r = 0; r < NUM_RANKS; r++) begin : g_rank
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            logic act_ld;
            logic pre_ld;
            assign act_ld = issue && (cmd.op == CMD_ACT) && rank_sel[r] && bank_sel[b];
            assign pre_ld = issue && (cmd.op == CMD_PRE) && rank_sel[r] && bank_sel[b];

            ddr_bank_timer #(
                .CW   (CW),
                .TRCD (TRCD),
                .TRAS (TRAS),
                .TRP  (TRP)
            ) u_bank_timer (
                .clk     (clk),
                .rst     (rst),
                .act_ld  (act_ld),
                .pre_ld  (pre_ld),
                .is_open (bank_open[r][b]),
                .rcd_ok  (rcd_ok[r][b]),
                .ras_ok  (ras_ok[r][b]),
                .rp_ok   (rp_ok[r][b])
            );
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                trrd_q[r] <= '0;
                trfc_q[r] <= '0;
            end else begin
                if (issue && rank_sel[r] && cmd.op == CMD_ACT) trrd_q[r] <= CW'(TRRD - 1);
                else if (trrd_q[r] != '0)                       trrd_q[r] <= trrd_q[r] - CW'(1);
                if (issue && rank_sel[r] && cmd.op == CMD_REF) trfc_q[r] <= CW'(TRFC - 1);
                else if (trfc_q[r] != '0)                       trfc_q[r] <= trfc_q[r] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tccd_q    <= '0;
            phy_valid <= 1'b0;
            phy_cmd   <= '0;
            proto_err <= 1'b0;
        end else begin
            if (issue && (cmd.op == CMD_RD || cmd.op == CMD_WR)) tccd_q <= CW'(TCCD - 1);
            else if (tccd_q != '0)                               tccd_q <= tccd_q - CW'(1);
            if (issue) begin
                phy_valid <= 1'b1;
                phy_cmd   <= cmd;
            end else if (phy_ready) begin
                phy_valid <= 1'b0;
            end
            if (drop) proto_err <= 1'b1;
        end
    end

`ifdef DDR_CMD_GATE_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (cmd_valid && !cmd_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 16'h0;
`endif

endmodule

// File: tb/tb_ddr_cmd_timing_gate.sv
// Directed-vector bench for ddr_cmd_timing_gate with an issue scoreboard and cycle-accurate wait checks.
// Build with +define+DDR_CMD_GATE_STATS_EN to also check the stall counter against its model.
module tb_ddr_cmd_timing_gate;
    import ddr_types_pkg::*;

    localparam int CMD_W = $bits(ddr_cmd_t);

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    ddr_cmd_t    cmd;
    logic        phy_valid;
    logic        phy_ready;
    ddr_cmd_t    phy_cmd;
    logic        bank_busy;
    logic        rank_busy;
    logic        proto_err;
    logic [15:0] stall_cycles;

    logic [CMD_W-1:0] exp_q[$];
    logic [CMD_W-1:0] mon_exp;
    int n_vec     = 0;
    int n_err     = 0;
    int exp_stall = 0;

    ddr_cmd_timing_gate dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd          (cmd),
        .phy_valid    (phy_valid),
        .phy_ready    (phy_ready),
        .phy_cmd      (phy_cmd),
        .bank_busy    (bank_busy),
        .rank_busy    (rank_busy),
        .proto_err    (proto_err),
        .stall_cycles (stall_cycles)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    function automatic ddr_cmd_t mk(input ddr_op_e op, input int r, input int b);
        ddr_cmd_t c;
        c.op   = op;
        c.rank = DDR_RANK_W'(r);
        c.bank = DDR_BANK_W'(b);
        return c;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_stall(input string name);
`ifdef DDR_CMD_GATE_STATS_EN
        check(name, int'(stall_cycles), exp_stall);
`else
        check(name, int'(stall_cycles), 0);
`endif
    endtask

    // Driver: called at #1 after a posedge; returns at #1 after the accepting posedge.
    // exp_wait < 0 means the wait length is not checked.
    task automatic send(input string name, input ddr_cmd_t c, input bit will_issue,
                        input int exp_wait, input int exp_nb, input int exp_nr);
        int waited;
        int nb;
        int nr;
        bit ok;
        cmd       = c;
        cmd_valid = 1'b1;
        waited    = 0;
        nb        = 0;
        nr        = 0;
        ok        = 1'b0;
        while (!ok && waited <= 600) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                if (will_issue) exp_q.push_back(c);
            end else begin
                nb += int'(bank_busy);
                nr += int'(rank_busy);
                waited++;
            end
        end
        exp_stall += waited;
        check({name, "_accepted"}, int'(ok), 1);
        if (exp_wait >= 0) begin
            check({name, "_wait"}, waited, exp_wait);
            check({name, "_bank_busy"}, nb, exp_nb);
            check({name, "_rank_busy"}, nr, exp_nr);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd       = '0;
    endtask

    // Scoreboard monitor: every transfer on the PHY side must match the next expected command.
    always @(negedge clk) begin
        if (!rst && phy_valid && phy_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_issue: got %h expected none", phy_cmd);
            end else begin
                mon_exp = exp_q.pop_front();
                if (phy_cmd !== mon_exp) begin
                    n_err++;
                    $display("FAIL issue_order: got %h expected %h", phy_cmd, mon_exp);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd       = '0;
        phy_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_phy_valid", int'(phy_valid), 0);
        check("rst_phy_cmd", int'(phy_cmd), 0);
        check("rst_proto_err", int'(proto_err), 0);
        check("rst_stall", int'(stall_cycles), 0);
        check("rst_cmd_ready", int'(cmd_ready), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // tRCD: RD presented the cycle after ACT waits 25 cycles
        send("act_r0b3", mk(CMD_ACT, 0, 3), 1'b1, 0, 0, 0);
        send("rd_r0b3", mk(CMD_RD, 0, 3), 1'b1, 25, 25, 0);

        // tRRD within rank 0, other rank unaffected
        send("act_r0b0", mk(CMD_ACT, 0, 0), 1'b1, 0, 0, 0);
        send("act_r0b1", mk(CMD_ACT, 0, 1), 1'b1, 7, 0, 7);
        send("act_r1b0", mk(CMD_ACT, 1, 0), 1'b1, 0, 0, 0);

        // Protocol errors are consumed, never issued
        send("rd_closed_r1b5", mk(CMD_RD, 1, 5), 1'b0, 0, 0, 0);
        @(negedge clk);
        check("proto_err_set", int'(proto_err), 1);
        @(posedge clk);
        #1;
        send("act_bad_rank", mk(CMD_ACT, 2, 0), 1'b0, 0, 0, 0);
        check("proto_err_sticky", int'(proto_err), 1);
        check_stall("stall_after_basic");

        // Back-pressure: phy_cmd held 5 cycles, new command stalls, then drain+issue same cycle
        repeat (10) @(posedge clk);
        #1;
        send("act_r1b1", mk(CMD_ACT, 1, 1), 1'b1, 0, 0, 0);
        phy_ready = 1'b0;
        cmd       = mk(CMD_ACT, 0, 2);
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_phy_valid", int'(phy_valid), 1);
            check("hold_phy_cmd", int'(phy_cmd), int'(mk(CMD_ACT, 1, 1)));
            check("hold_cmd_ready", int'(cmd_ready), 0);
        end
        exp_stall += 5;
        @(posedge clk);
        #1;
        phy_ready = 1'b1;
        @(negedge clk);
        check("drain_cmd_ready", int'(cmd_ready), 1);
        if (cmd_ready) exp_q.push_back(mk(CMD_ACT, 0, 2));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd       = '0;
        check_stall("stall_after_hold");

        // Close rank 0, refresh it: rank 1 free, rank 0 waits tRFC
        send("pre_r0b0", mk(CMD_PRE, 0, 0), 1'b1, -1, 0, 0);
        send("pre_r0b1", mk(CMD_PRE, 0, 1), 1'b1, -1, 0, 0);
        send("pre_r0b2", mk(CMD_PRE, 0, 2), 1'b1, -1, 0, 0);
        send("pre_r0b3", mk(CMD_PRE, 0, 3), 1'b1, -1, 0, 0);
        send("ref_r0", mk(CMD_REF, 0, 0), 1'b1, -1, 0, 0);
        send("act_r1b2", mk(CMD_ACT, 1, 2), 1'b1, 0, 0, 0);
        send("act_r0b4_trfc", mk(CMD_ACT, 0, 4), 1'b1, 470, 0, 470);

        // tRCD, tCCD, tRAS, tRP on one bank
        send("wr_r0b4", mk(CMD_WR, 0, 4), 1'b1, 25, 25, 0);
        send("rd_r0b4_tccd", mk(CMD_RD, 0, 4), 1'b1, 7, 7, 0);
        send("pre_r0b4_tras", mk(CMD_PRE, 0, 4), 1'b1, 17, 17, 0);
        send("act_r0b4_trp", mk(CMD_ACT, 0, 4), 1'b1, 25, 25, 0);
        check_stall("stall_after_timing");

        // Reset while a REF is held on the PHY side and tRFC is counting
        send("pre_r0b4", mk(CMD_PRE, 0, 4), 1'b1, -1, 0, 0);
        send("ref_r0_b", mk(CMD_REF, 0, 0), 1'b1, -1, 0, 0);
        phy_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_phy_valid", int'(phy_valid), 1);
        rst = 1'b1;
        exp_q.delete();
        exp_stall = 0;
        #1;
        check("midrst_phy_valid", int'(phy_valid), 0);
        check("midrst_proto_err", int'(proto_err), 0);
        check("midrst_stall", int'(stall_cycles), 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        phy_ready = 1'b1;
        send("act_after_rst", mk(CMD_ACT, 0, 0), 1'b1, 0, 0, 0);
        check_stall("stall_after_rst");

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
